// File: rtl/collection_sweep_controller_pkg.sv
// Shared types and pipeline constants for the collector clear-on-read sweep.
// The controller and its return accumulator both import this package.
package collection_sweep_controller_pkg;

    // Pipeline globals the sweep must agree with.
    localparam int PIPE_ADDR_WIDTH     = 12;
    localparam int OUTPUT_READ_LATENCY = 5;
    localparam int DATA_WIDTH          = 38;
    localparam int PCOEFF_WIDTH        = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_SWEEP = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } sweep_state_e;

    // Width of a down-counter that must hold values 0..count-1.
    function automatic int down_counter_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/collection_sweep_controller_accumulator.sv
// Re-aligns collector read returns with the issue stream and sums them.
// Also reports whether the alignment pipe will be empty after this edge.
module sweep_return_accumulator
    import collection_sweep_controller_pkg::*;
#(
    parameter int ADDR_WIDTH   = PIPE_ADDR_WIDTH,
    parameter int READ_LATENCY = OUTPUT_READ_LATENCY,
    parameter int TOTAL_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PCOEFF_WIDTH-1:0] count_in,
    output logic [TOTAL_WIDTH-1:0]  total_sum,
    output logic [ADDR_WIDTH+2:0]   total_count,
    output logic                    pipe_empty_next
);

    logic [READ_LATENCY-1:0] valid_sr;
    logic [READ_LATENCY-1:0] valid_sr_next;
    logic                    tap;

    // The oldest bit falls off the end; only the shifted-in view matters.
    assign valid_sr_next   = READ_LATENCY'({valid_sr, valid_in});
    assign tap             = valid_sr[READ_LATENCY-1];
    assign pipe_empty_next = ~|valid_sr_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the valid pipe is reset like any control register because it
            // gates accumulation; leaving it X would corrupt the first batch total.
            valid_sr    <= '0;
            total_sum   <= '0;
            total_count <= '0;
        end else begin
            valid_sr <= valid_sr_next;
            if (clear) begin
                total_sum   <= '0;
                total_count <= '0;
            end else if (tap) begin
                total_sum   <= total_sum + TOTAL_WIDTH'(data_in);
                total_count <= total_count + (ADDR_WIDTH+3)'(count_in);
            end
        end
    end

endmodule

// File: rtl/collection_sweep_controller.sv
// Drains the write pipe, sweeps every collector address once (clear-on-read),
// and hands the accumulated batch total to the consumer via valid/ack.
module collection_sweep_controller
    import collection_sweep_controller_pkg::*;
#(
    parameter int ADDR_WIDTH   = PIPE_ADDR_WIDTH,
    parameter int READ_LATENCY = OUTPUT_READ_LATENCY,
    parameter int DRAIN_CYCLES = 8,
    parameter int TOTAL_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    hold,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   readAddr,
    output logic                    readActive,
    input  logic [DATA_WIDTH-1:0]   summedDataIn,
    input  logic [PCOEFF_WIDTH-1:0] pcoeffCountIn,
    output logic                    resultValid,
    input  logic                    resultAck,
    output logic [TOTAL_WIDTH-1:0]  totalSum,
    output logic [ADDR_WIDTH+2:0]   totalCount
);

    localparam int                    DRAIN_W    = down_counter_width(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    if (TOTAL_WIDTH < DATA_WIDTH + ADDR_WIDTH) begin : g_width_check
        $error("TOTAL_WIDTH cannot hold a full sweep of summedDataIn");
    end

    sweep_state_e       state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               clear_totals;
    logic               pipe_empty_next;

    // Totals survive in IDLE for late readers and only clear when a batch begins.
    assign clear_totals = (state == ST_IDLE) && start;

    sweep_return_accumulator #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .TOTAL_WIDTH  (TOTAL_WIDTH)
    ) u_accumulator (
        .clk             (clk),
        .rstn            (rstn),
        .clear           (clear_totals),
        .valid_in        (readActive),
        .data_in         (summedDataIn),
        .count_in        (pcoeffCountIn),
        .total_sum       (totalSum),
        .total_count     (totalCount),
        .pipe_empty_next (pipe_empty_next)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; a blocking '=' would make order of statements matter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            readAddr    <= '0;
            readActive  <= 1'b0;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        readAddr <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state <= ST_SWEEP;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= ST_SWEEP;
                        readAddr <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end

                ST_SWEEP: begin
                    // The address advances only after it was actually issued,
                    // so a hold bubble keeps presenting the next unread address.
                    if (readActive && (readAddr == LAST_ADDR)) begin
                        state      <= ST_FLUSH;
                        readActive <= 1'b0;
                        readAddr   <= '0;
                    end else begin
                        readActive <= !hold;
                        if (readActive) begin
                            readAddr <= readAddr + ADDR_WIDTH'(1);
                        end
                    end
                end

                ST_FLUSH: begin
                    // Leave on the edge that absorbs the last return, so the
                    // totals are already final when resultValid rises.
                    if (pipe_empty_next) begin
                        state       <= ST_DONE;
                        resultValid <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (resultAck) begin
                        state       <= ST_IDLE;
                        resultValid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    readActive  <= 1'b0;
                    resultValid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
